// File: rtl/seg_pkg.sv
// Shared types and helpers for the 7-segment code sequencer.
package seg_pkg;

  localparam int CODE_W = 3;

  typedef enum logic [1:0] {
    MANUAL    = 2'd0,
    AUTO      = 2'd1,
    AUTO_HOLD = 2'd2
  } seq_state_e;

  // dir=0 counts up, dir=1 counts down; both wrap inside 0..max
  function automatic logic [CODE_W-1:0] next_code(input logic [CODE_W-1:0] code,
                                                  input logic [CODE_W-1:0] max,
                                                  input logic              dir);
    if (dir) next_code = (code == '0) ? max : code - 1'b1;
    else     next_code = (code == max) ? '0 : code + 1'b1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus run-length debouncer for one raw button.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          sampled;

  assign sampled = sync[1];

  // A new level is accepted only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync       <= '0;
      cnt        <= '0;
      level      <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      sync       <= {sync[0], raw};
      rise_pulse <= 1'b0;
      if (sampled != level) begin
        if (cnt == CNT_TERM) begin
          level      <= sampled;
          cnt        <= '0;
          rise_pulse <= sampled;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/seg_code_sequencer.sv
// Generates the 3-bit A/B/C code for the 7-segment decoder, manual or timed stepping.
// Build option: SEQ_DIR_EN adds btn_dir, a debounced button that toggles count direction.
module seg_code_sequencer
  import seg_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int AUTO_PERIOD     = 50,
  parameter int CODE_MAX        = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_step,
  input  logic btn_mode,
  input  logic hold,
`ifdef SEQ_DIR_EN
  input  logic btn_dir,
`endif
  output logic code_a,
  output logic code_b,
  output logic code_c,
  output logic auto_mode,
  output logic step_pulse
);

  localparam int TW = $clog2(AUTO_PERIOD);
  localparam logic [TW-1:0]     T_TERM = TW'(AUTO_PERIOD - 1);
  localparam logic [CODE_W-1:0] C_MAX  = CODE_W'(CODE_MAX);

  seq_state_e        state, state_nx;
  logic [TW-1:0]     timer, timer_nx;
  logic [CODE_W-1:0] code;
  logic              adv;
  logic              step_p, mode_p, dir;
  logic              unused_step_lvl, unused_mode_lvl;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
    .clk(clk), .rst_n(rst_n), .raw(btn_step), .level(unused_step_lvl), .rise_pulse(step_p)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk(clk), .rst_n(rst_n), .raw(btn_mode), .level(unused_mode_lvl), .rise_pulse(mode_p)
  );

`ifdef SEQ_DIR_EN
  logic dir_p, unused_dir_lvl;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dir (
    .clk(clk), .rst_n(rst_n), .raw(btn_dir), .level(unused_dir_lvl), .rise_pulse(dir_p)
  );

  // The current advance always uses the old direction; a toggle lands afterwards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     dir <= 1'b0;
    else if (dir_p) dir <= ~dir;
  end
`else
  assign dir = 1'b0;
`endif

  // Mode press has priority over step; terminal count and step merge into one advance
  always_comb begin
    state_nx = state;
    timer_nx = timer;
    adv      = 1'b0;
    unique case (state)
      MANUAL: begin
        if (mode_p) begin
          state_nx = AUTO;
          timer_nx = '0;
        end else begin
          adv = step_p;
        end
      end
      AUTO: begin
        if (mode_p) begin
          state_nx = MANUAL;
        end else begin
          if (step_p || timer == T_TERM) begin
            adv      = 1'b1;
            timer_nx = '0;
          end else begin
            timer_nx = timer + 1'b1;
          end
          if (hold) state_nx = AUTO_HOLD;
        end
      end
      AUTO_HOLD: begin
        if (mode_p) begin
          state_nx = MANUAL;
        end else begin
          adv = step_p;
          if (!hold) state_nx = AUTO;
        end
      end
      default: state_nx = MANUAL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= MANUAL;
      timer      <= '0;
      code       <= '0;
      auto_mode  <= 1'b0;
      step_pulse <= 1'b0;
    end else begin
      state      <= state_nx;
      timer      <= timer_nx;
      auto_mode  <= (state_nx != MANUAL);
      step_pulse <= adv;
      if (adv) code <= next_code(code, C_MAX, dir);
    end
  end

  assign code_a = code[2];
  assign code_b = code[1];
  assign code_c = code[0];

endmodule
